// File: rtl/branch_sched_pkg.sv
// rtl/branch_sched_pkg.sv - shared instruction header: branch decode, FSM states, forward selects
// Used by the ID-stage decode logic and the branch scheduler.
package branch_sched_pkg;

  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;

  // REGIMM sub-opcodes live in the rt field
  localparam logic [4:0] RI_BLTZ = 5'h00;
  localparam logic [4:0] RI_BGEZ = 5'h01;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT1   = 2'd1,
    ST_RESOLVE = 2'd2
  } state_t;

  function automatic logic is_branch(input logic [5:0] op, input logic [4:0] ri);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) || (op == OP_BGTZ) ||
           ((op == OP_REGIMM) && ((ri == RI_BLTZ) || (ri == RI_BGEZ)));
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  // Stall cycles one source register needs before the comparator can read it
  function automatic logic [1:0] need_for(
    input logic [4:0] src,
    input logic       reg_write_e,
    input logic       mem_to_reg_e,
    input logic [4:0] write_reg_e,
    input logic       reg_write_m,
    input logic       mem_to_reg_m,
    input logic [4:0] write_reg_m
  );
    logic [1:0] n;
    n = 2'd0;
    if (src != 5'd0) begin
      if (reg_write_e && (write_reg_e == src))
        n = mem_to_reg_e ? 2'd2 : 2'd1;
      else if (reg_write_m && mem_to_reg_m && (write_reg_m == src))
        n = 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - comparator operand source select for one register
// MEM ALU results win over WB results; register 0 is never forwarded.
module fwd_sel
  import branch_sched_pkg::*;
(
  input  logic [4:0] src,
  input  logic       reg_write_m,
  input  logic       mem_to_reg_m,
  input  logic [4:0] write_reg_m,
  input  logic       reg_write_w,
  input  logic [4:0] write_reg_w,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (src != 5'd0) begin
      if (reg_write_m && !mem_to_reg_m && (write_reg_m == src))
        sel = FWD_MEM;
      else if (reg_write_w && (write_reg_w == src))
        sel = FWD_WB;
    end
  end

endmodule

// File: rtl/branch_sched.sv
// rtl/branch_sched.sv - ID-stage branch hazard scheduler with forwarding and statistics
// Stalls a branch until its sources are forwardable, then resolves it; the delay slot always runs.
module branch_sched
  import branch_sched_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr_D,
  input  logic             RegWrite_E,
  input  logic             MemToReg_E,
  input  logic [4:0]       WriteReg_E,
  input  logic             RegWrite_M,
  input  logic             MemToReg_M,
  input  logic [4:0]       WriteReg_M,
  input  logic             RegWrite_W,
  input  logic [4:0]       WriteReg_W,
  input  logic             Branch,
  output logic             Stall,
  output logic             FlushE,
  output logic [1:0]       FwdRS_D,
  output logic [1:0]       FwdRT_D,
  output logic             PCSel,
  output logic [CNT_W-1:0] BrCnt,
  output logic [CNT_W-1:0] TakenCnt
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       br_d;
  logic [1:0] need_rs;
  logic [1:0] need_rt;
  logic [1:0] need;
  logic       resolve;
  logic       unused_imm;
  state_t     state;
  state_t     state_nx;

  assign op         = Instr_D[31:26];
  assign rs         = Instr_D[25:21];
  assign br_d       = is_branch(op, Instr_D[20:16]);
  // Single-source branches carry a sub-opcode in rt, so treat it as $0
  assign rt         = uses_rt(op) ? Instr_D[20:16] : 5'd0;
  assign unused_imm = ^Instr_D[15:0];

  assign need_rs = need_for(rs, RegWrite_E, MemToReg_E, WriteReg_E,
                            RegWrite_M, MemToReg_M, WriteReg_M);
  assign need_rt = need_for(rt, RegWrite_E, MemToReg_E, WriteReg_E,
                            RegWrite_M, MemToReg_M, WriteReg_M);
  assign need    = (need_rs > need_rt) ? need_rs : need_rt;

  fwd_sel u_fwd_rs (
    .src          (rs),
    .reg_write_m  (RegWrite_M),
    .mem_to_reg_m (MemToReg_M),
    .write_reg_m  (WriteReg_M),
    .reg_write_w  (RegWrite_W),
    .write_reg_w  (WriteReg_W),
    .sel          (FwdRS_D)
  );

  fwd_sel u_fwd_rt (
    .src          (rt),
    .reg_write_m  (RegWrite_M),
    .mem_to_reg_m (MemToReg_M),
    .write_reg_m  (WriteReg_M),
    .reg_write_w  (RegWrite_W),
    .write_reg_w  (WriteReg_W),
    .sel          (FwdRT_D)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    Stall    = 1'b0;
    resolve  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (br_d) begin
          if (need == 2'd2) begin
            Stall    = 1'b1;
            state_nx = ST_WAIT1;
          end else if (need == 2'd1) begin
            Stall    = 1'b1;
            state_nx = ST_RESOLVE;
          end else begin
            resolve  = 1'b1;
          end
        end
      end
      ST_WAIT1: begin
        Stall    = 1'b1;
        state_nx = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        resolve  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign PCSel  = resolve & Branch;
  assign FlushE = Stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      BrCnt    <= '0;
      TakenCnt <= '0;
    end else if (resolve) begin
      if (BrCnt != '1)
        BrCnt <= BrCnt + CNT_W'(1);
      if (Branch && (TakenCnt != '1))
        TakenCnt <= TakenCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_sched.sv
// tb/tb_branch_sched.sv - directed self-checking bench for branch_sched
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_branch_sched;

  logic        clk;
  logic        reset;
  logic [31:0] Instr_D;
  logic        RegWrite_E, MemToReg_E;
  logic [4:0]  WriteReg_E;
  logic        RegWrite_M, MemToReg_M;
  logic [4:0]  WriteReg_M;
  logic        RegWrite_W;
  logic [4:0]  WriteReg_W;
  logic        Branch;
  logic        Stall, FlushE, PCSel;
  logic [1:0]  FwdRS_D, FwdRT_D;
  logic [15:0] BrCnt, TakenCnt;

  int n_cmp = 0;
  int n_bad = 0;

  branch_sched #(.CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr_D    (Instr_D),
    .RegWrite_E (RegWrite_E),
    .MemToReg_E (MemToReg_E),
    .WriteReg_E (WriteReg_E),
    .RegWrite_M (RegWrite_M),
    .MemToReg_M (MemToReg_M),
    .WriteReg_M (WriteReg_M),
    .RegWrite_W (RegWrite_W),
    .WriteReg_W (WriteReg_W),
    .Branch     (Branch),
    .Stall      (Stall),
    .FlushE     (FlushE),
    .FwdRS_D    (FwdRS_D),
    .FwdRT_D    (FwdRT_D),
    .PCSel      (PCSel),
    .BrCnt      (BrCnt),
    .TakenCnt   (TakenCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_pipe();
    RegWrite_E = 0; MemToReg_E = 0; WriteReg_E = 0;
    RegWrite_M = 0; MemToReg_M = 0; WriteReg_M = 0;
    RegWrite_W = 0; WriteReg_W = 0;
  endtask

  initial begin
    reset = 1; Instr_D = 32'h0; Branch = 0;
    clear_pipe();
    tick(); tick();
    reset = 0;
    sample();
    check("rst_stall", Stall, 0);
    check("rst_flush", FlushE, 0);
    check("rst_pcsel", PCSel, 0);
    check("rst_brcnt", BrCnt, 0);
    check("rst_taken", TakenCnt, 0);

    // beq $1,$2, nothing in flight, taken: resolves immediately
    tick();
    Instr_D = enc(6'h04, 5'd1, 5'd2, 16'h0004); Branch = 1;
    sample();
    check("beq_stall", Stall, 0);
    check("beq_pcsel", PCSel, 1);
    check("beq_flush", FlushE, 0);
    tick();
    Instr_D = 32'h0; Branch = 0;
    check("beq_brcnt", BrCnt, 1);
    check("beq_taken", TakenCnt, 1);

    // lw $3 in EX, bne $3,$0 in ID: two stall cycles then WB forward
    Instr_D = enc(6'h05, 5'd3, 5'd0, 16'h0010); Branch = 1;
    RegWrite_E = 1; MemToReg_E = 1; WriteReg_E = 5'd3;
    sample();
    check("lw_s1_stall", Stall, 1);
    check("lw_s1_flush", FlushE, 1);
    check("lw_s1_pcsel", PCSel, 0);
    tick();
    clear_pipe();
    RegWrite_M = 1; MemToReg_M = 1; WriteReg_M = 5'd3;
    sample();
    check("lw_s2_stall", Stall, 1);
    check("lw_s2_flush", FlushE, 1);
    check("lw_s2_pcsel", PCSel, 0);
    check("lw_s2_fwdrs", FwdRS_D, 0);
    tick();
    clear_pipe();
    RegWrite_W = 1; WriteReg_W = 5'd3;
    sample();
    check("lw_res_stall", Stall, 0);
    check("lw_res_fwdrs", FwdRS_D, 2);
    check("lw_res_fwdrt", FwdRT_D, 0);
    check("lw_res_pcsel", PCSel, 1);
    tick();
    clear_pipe(); Instr_D = 32'h0; Branch = 0;
    check("lw_brcnt", BrCnt, 2);
    check("lw_taken", TakenCnt, 2);

    // add $4 in EX, bgtz $4 not taken: one stall then MEM forward (beats WB)
    Instr_D = enc(6'h07, 5'd4, 5'd0, 16'h0008); Branch = 0;
    RegWrite_E = 1; MemToReg_E = 0; WriteReg_E = 5'd4;
    sample();
    check("add_s1_stall", Stall, 1);
    check("add_s1_pcsel", PCSel, 0);
    tick();
    clear_pipe();
    RegWrite_M = 1; MemToReg_M = 0; WriteReg_M = 5'd4;
    RegWrite_W = 1; WriteReg_W = 5'd4;
    sample();
    check("add_res_stall", Stall, 0);
    check("add_res_fwdrs", FwdRS_D, 1);
    check("add_res_pcsel", PCSel, 0);
    tick();
    clear_pipe(); Instr_D = 32'h0;
    check("add_brcnt", BrCnt, 3);
    check("add_taken", TakenCnt, 2);

    // beq $0,$0 with every stage writing $0: never a hazard or forward
    Instr_D = enc(6'h04, 5'd0, 5'd0, 16'h0001); Branch = 1;
    RegWrite_E = 1; MemToReg_E = 1; WriteReg_E = 5'd0;
    RegWrite_M = 1; MemToReg_M = 0; WriteReg_M = 5'd0;
    RegWrite_W = 1; WriteReg_W = 5'd0;
    sample();
    check("r0_stall", Stall, 0);
    check("r0_fwdrs", FwdRS_D, 0);
    check("r0_fwdrt", FwdRT_D, 0);
    check("r0_pcsel", PCSel, 1);
    tick();
    clear_pipe(); Instr_D = 32'h0; Branch = 0;
    check("r0_brcnt", BrCnt, 4);
    check("r0_taken", TakenCnt, 3);

    // non-branch with a load hazard on its rs: no stall, no count
    Instr_D = {6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h20}; Branch = 1;
    RegWrite_E = 1; MemToReg_E = 1; WriteReg_E = 5'd4;
    sample();
    check("nb_stall", Stall, 0);
    check("nb_pcsel", PCSel, 0);
    tick();
    clear_pipe(); Instr_D = 32'h0; Branch = 0;
    check("nb_brcnt", BrCnt, 4);

    // bgez $6: writers of $1 (its sub-opcode field) must be ignored
    Instr_D = enc(6'h01, 5'd6, 5'd1, 16'h0002); Branch = 1;
    RegWrite_E = 1; MemToReg_E = 1; WriteReg_E = 5'd1;
    RegWrite_M = 1; MemToReg_M = 0; WriteReg_M = 5'd1;
    sample();
    check("bgez_stall", Stall, 0);
    check("bgez_fwdrt", FwdRT_D, 0);
    check("bgez_fwdrs", FwdRS_D, 0);
    check("bgez_pcsel", PCSel, 1);
    tick();
    clear_pipe(); Instr_D = 32'h0; Branch = 0;
    check("bgez_brcnt", BrCnt, 5);
    check("bgez_taken", TakenCnt, 4);

    // reset while in WAIT1
    Instr_D = enc(6'h04, 5'd7, 5'd8, 16'h0003); Branch = 1;
    RegWrite_E = 1; MemToReg_E = 1; WriteReg_E = 5'd7;
    sample();
    check("w1_stall", Stall, 1);
    tick();
    clear_pipe();
    reset = 1;
    sample();
    check("w1_hold_stall", Stall, 1);
    tick();
    reset = 0; Instr_D = 32'h0; Branch = 0;
    sample();
    check("w1_rst_stall", Stall, 0);
    check("w1_rst_flush", FlushE, 0);
    check("w1_rst_pcsel", PCSel, 0);
    check("w1_rst_brcnt", BrCnt, 0);
    check("w1_rst_taken", TakenCnt, 0);
    tick();
    Instr_D = enc(6'h04, 5'd7, 5'd8, 16'h0003); Branch = 0;
    sample();
    check("post_rst_stall", Stall, 0);
    tick();
    Instr_D = 32'h0;
    check("post_rst_brcnt", BrCnt, 1);
    check("post_rst_taken", TakenCnt, 0);

    // saturation: drive taken branches until both counters hit all-ones
    reset = 1;
    tick();
    reset = 0;
    Instr_D = enc(6'h04, 5'd1, 5'd2, 16'h0004); Branch = 1;
    for (int i = 0; i < 65534; i++) tick();
    check("sat_pre_brcnt", BrCnt, 16'hFFFE);
    check("sat_pre_taken", TakenCnt, 16'hFFFE);
    tick();
    check("sat_brcnt", BrCnt, 16'hFFFF);
    check("sat_taken", TakenCnt, 16'hFFFF);
    tick();
    check("sat_hold_brcnt", BrCnt, 16'hFFFF);
    check("sat_hold_taken", TakenCnt, 16'hFFFF);
    Branch = 0;
    tick();
    Instr_D = 32'h0;
    check("sat_nt_brcnt", BrCnt, 16'hFFFF);
    check("sat_nt_taken", TakenCnt, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
